// File: rtl/systolic_seq_pkg.sv
// -----------------------------------------------------------------------------
// systolic_seq_pkg
// Shared types and default constants for the systolic tile sequencer.
//   seq_state_e     : sequencer FSM states (IDLE, LOAD, COMPUTE, DRAIN, DONE)
//   DEF_*           : default parameter values for the sequencer
//   ctr_width()     : width of a counter holding 0..n-1 (at least one bit)
// -----------------------------------------------------------------------------
package systolic_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } seq_state_e;

    localparam int DEF_MATRIX_SIZE = 2;
    localparam int DEF_PE_LATENCY  = 4;
    localparam int DEF_CNT_W       = 16;

    // A PE_LATENCY of 1 still needs a one-bit slot counter.
    function automatic int ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_skew_shreg.sv
// -----------------------------------------------------------------------------
// systolic_skew_shreg
// N-bit right-shift register producing the staggered per-row multiply enables.
// Bit N-1 is the insertion point, so the first row to be enabled is N-1 and
// each further shift walks the enable wavefront towards bit 0.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   shift_en      : shift right by one, inserting ins at bit N-1
//   ins           : bit inserted at the top on a shift
//   clear         : synchronous clear (wins over shift_en)
//   q             : register contents
//   shift_zero    : register would be all-zero after a shift with current ins
// -----------------------------------------------------------------------------
module systolic_skew_shreg #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         shift_en,
    input  logic         ins,
    input  logic         clear,
    output logic [N-1:0] q,
    output logic         shift_zero
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;
    logic [N-1:0] shifted;

    assign shifted    = {ins, q_q[N-1:1]};
    assign shift_zero = (shifted == '0);
    assign q          = q_q;

    always_comb begin
        q_d = q_q;
        if (clear) begin
            q_d = '0;
        end else if (shift_en) begin
            q_d = shifted;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/systolic_tile_sequencer.sv
// -----------------------------------------------------------------------------
// systolic_tile_sequencer
// Sequences one tile on an MATRIX_SIZE x MATRIX_SIZE weight-stationary systolic
// array: row-by-row weight load, staggered multiply enables (one issue slot
// every PE_LATENCY cycles), drain, then a one-cycle done pulse. Tiles may run
// back to back without reset.
// Optional feature macro: SYSTOLIC_SEQ_STALL_EN adds the stall input, which
// freezes sequencing while the activation feeder is starved.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   cmd_valid/ready : tile command handshake (ready only in IDLE)
//   cmd_vec_count   : activation vectors in the tile, sampled on handshake
//   stall           : freeze request (only with SYSTOLIC_SEQ_STALL_EN)
//   load_weight     : one-hot row weight-load strobe
//   weight_row_sel  : index of the row being loaded
//   enable_mult     : per-row multiply enables, bit N-1 enabled first
//   vec_issue       : one-cycle pulse per activation vector issued
//   busy            : sequencer not idle
//   done            : one-cycle completion pulse
// -----------------------------------------------------------------------------
module systolic_tile_sequencer
    import systolic_seq_pkg::*;
#(
    parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
    parameter int PE_LATENCY  = DEF_PE_LATENCY,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [CNT_W-1:0]               cmd_vec_count,
`ifdef SYSTOLIC_SEQ_STALL_EN
    input  logic                           stall,
`endif
    output logic [MATRIX_SIZE-1:0]         load_weight,
    output logic [$clog2(MATRIX_SIZE)-1:0] weight_row_sel,
    output logic [MATRIX_SIZE-1:0]         enable_mult,
    output logic                           vec_issue,
    output logic                           busy,
    output logic                           done
);

    localparam int N      = MATRIX_SIZE;
    localparam int ROW_W  = $clog2(MATRIX_SIZE);
    localparam int SLOT_W = ctr_width(PE_LATENCY);

    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(N - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PE_LATENCY - 1);
    localparam logic [N-1:0]      ROW0_HOT  = N'(1);

    seq_state_e        state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [N-1:0]      load_weight_q, load_weight_d;
    logic [ROW_W-1:0]  row_sel_q, row_sel_d;
    logic              vec_issue_q, vec_issue_d;
    logic              done_q, done_d;

    logic              sh_shift;
    logic              sh_ins;
    logic              sh_clear;
    logic              sh_zero;
    logic [N-1:0]      sh_q;

    logic              stall_act;
    logic              slot_end;
    logic [ROW_W-1:0]  row_inc;
    logic [CNT_W-1:0]  issued_inc;

    assign slot_end   = (slot_q == LAST_SLOT);
    assign row_inc    = row_q + ROW_W'(1);
    assign issued_inc = issued_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        slot_d        = slot_q;
        issued_d      = issued_q;
        count_d       = count_q;
        load_weight_d = '0;
        row_sel_d     = row_sel_q;
        vec_issue_d   = 1'b0;
        done_d        = 1'b0;
        sh_shift      = 1'b0;
        sh_ins        = 1'b0;
        sh_clear      = 1'b0;

        // A stalled cycle leaves every counter and the enable wavefront
        // untouched; the strobes default to 0 above.
        if (!stall_act) begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        count_d   = cmd_vec_count;
                        issued_d  = '0;
                        row_d     = '0;
                        slot_d    = '0;
                        row_sel_d = '0;
                        if (cmd_vec_count == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d       = LOAD;
                            load_weight_d = ROW0_HOT;
                        end
                    end
                end

                LOAD: begin
                    if (row_q == LAST_ROW) begin
                        // The edge after the last row load opens issue slot 0.
                        sh_shift    = 1'b1;
                        sh_ins      = 1'b1;
                        issued_d    = issued_inc;
                        vec_issue_d = 1'b1;
                        slot_d      = '0;
                        row_sel_d   = '0;
                        state_d     = (issued_inc == count_q) ? DRAIN : COMPUTE;
                    end else begin
                        row_d         = row_inc;
                        row_sel_d     = row_inc;
                        load_weight_d = ROW0_HOT << row_inc;
                    end
                end

                COMPUTE: begin
                    if (slot_end) begin
                        sh_shift    = 1'b1;
                        sh_ins      = 1'b1;
                        issued_d    = issued_inc;
                        vec_issue_d = 1'b1;
                        slot_d      = '0;
                        if (issued_inc == count_q) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end

                DRAIN: begin
                    if (slot_end) begin
                        sh_shift = 1'b1;
                        slot_d   = '0;
                        if (sh_zero) begin
                            state_d  = DONE;
                            done_d   = 1'b1;
                            sh_clear = 1'b1;
                        end
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end

                DONE: begin
                    state_d = IDLE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            row_q         <= '0;
            slot_q        <= '0;
            issued_q      <= '0;
            count_q       <= '0;
            load_weight_q <= '0;
            row_sel_q     <= '0;
            vec_issue_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            slot_q        <= slot_d;
            issued_q      <= issued_d;
            count_q       <= count_d;
            load_weight_q <= load_weight_d;
            row_sel_q     <= row_sel_d;
            vec_issue_q   <= vec_issue_d;
            done_q        <= done_d;
        end
    end

    systolic_skew_shreg #(
        .N (N)
    ) u_skew (
        .clk        (clk),
        .reset      (reset),
        .shift_en   (sh_shift),
        .ins        (sh_ins),
        .clear      (sh_clear),
        .q          (sh_q),
        .shift_zero (sh_zero)
    );

`ifdef SYSTOLIC_SEQ_STALL_EN
    logic hold_q, hold_d;

    assign stall_act = stall && (state_q inside {LOAD, COMPUTE, DRAIN});
    assign hold_d    = stall_act;

    // The wavefront itself is frozen in the shift register; only the
    // visible enables are masked for the cycles following a stalled edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign enable_mult = hold_q ? '0 : sh_q;
`else
    assign stall_act   = 1'b0;
    assign enable_mult = sh_q;
`endif

    assign cmd_ready      = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign load_weight    = load_weight_q;
    assign weight_row_sel = row_sel_q;
    assign vec_issue      = vec_issue_q;
    assign done           = done_q;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// -----------------------------------------------------------------------------
// tb_systolic_tile_sequencer
// Directed bench: instance A is N=2/L=4, instance B is N=4/L=1. Edge e counts
// clock edges from the accepting edge (e=0); outputs are sampled 1 time unit
// after each edge. Stall scenario present only with SYSTOLIC_SEQ_STALL_EN.
// -----------------------------------------------------------------------------
module tb_systolic_tile_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    // Instance A: N=2, L=4
    logic        a_cmd_valid = 1'b0;
    logic        a_cmd_ready;
    logic [15:0] a_cnt = '0;
    logic        a_stall = 1'b0;
    logic [1:0]  a_lw;
    logic [0:0]  a_sel;
    logic [1:0]  a_en;
    logic        a_vi, a_busy, a_done;

    // Instance B: N=4, L=1
    logic        b_cmd_valid = 1'b0;
    logic        b_cmd_ready;
    logic [15:0] b_cnt = '0;
    logic        b_stall = 1'b0;
    logic [3:0]  b_lw;
    logic [1:0]  b_sel;
    logic [3:0]  b_en;
    logic        b_vi, b_busy, b_done;

    int vectors = 0;
    int miscompares = 0;

    systolic_tile_sequencer #(
        .MATRIX_SIZE (2),
        .PE_LATENCY  (4),
        .CNT_W       (16)
    ) u_a (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (a_cmd_valid),
        .cmd_ready      (a_cmd_ready),
        .cmd_vec_count  (a_cnt),
`ifdef SYSTOLIC_SEQ_STALL_EN
        .stall          (a_stall),
`endif
        .load_weight    (a_lw),
        .weight_row_sel (a_sel),
        .enable_mult    (a_en),
        .vec_issue      (a_vi),
        .busy           (a_busy),
        .done           (a_done)
    );

    systolic_tile_sequencer #(
        .MATRIX_SIZE (4),
        .PE_LATENCY  (1),
        .CNT_W       (16)
    ) u_b (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (b_cmd_valid),
        .cmd_ready      (b_cmd_ready),
        .cmd_vec_count  (b_cnt),
`ifdef SYSTOLIC_SEQ_STALL_EN
        .stall          (b_stall),
`endif
        .load_weight    (b_lw),
        .weight_row_sel (b_sel),
        .enable_mult    (b_en),
        .vec_issue      (b_vi),
        .busy           (b_busy),
        .done           (b_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if ({a_lw, a_sel, a_en, a_vi, a_done, a_busy, a_cmd_ready} !== 9'b000000001) begin
            miscompares++;
            $display("FAIL reset_a got=%b exp=%b", {a_lw, a_sel, a_en, a_vi, a_done, a_busy, a_cmd_ready}, 9'b000000001);
        end
        vectors++;
        if ({b_lw, b_sel, b_en, b_vi, b_done, b_busy, b_cmd_ready} !== 14'b00000000000001) begin
            miscompares++;
            $display("FAIL reset_b got=%b exp=%b", {b_lw, b_sel, b_en, b_vi, b_done, b_busy, b_cmd_ready}, 14'b00000000000001);
        end
        reset = 1'b0;
        tick();
    endtask

    // N=2, L=4, count=2
    task automatic test_basic();
        logic [1:0] exp_lw, exp_en;
        logic       exp_vi, exp_done, exp_ready;
        a_cnt = 16'd2;
        a_cmd_valid = 1'b1;
        for (int e = 0; e <= 15; e++) begin
            tick();
            if (e == 0) a_cmd_valid = 1'b0;
            exp_lw    = (e == 0) ? 2'b01 : (e == 1) ? 2'b10 : 2'b00;
            exp_en    = (e >= 2 && e <= 5) ? 2'b10 : (e >= 6 && e <= 9) ? 2'b11 :
                        (e >= 10 && e <= 13) ? 2'b01 : 2'b00;
            exp_vi    = (e == 2 || e == 6);
            exp_done  = (e == 14);
            exp_ready = (e == 15);
            vectors++;
            if (a_lw !== exp_lw) begin
                miscompares++;
                $display("FAIL basic_load_weight e=%0d got=%b exp=%b", e, a_lw, exp_lw);
            end
            if (e < 2) begin
                vectors++;
                if (a_sel !== e[0:0]) begin
                    miscompares++;
                    $display("FAIL basic_row_sel e=%0d got=%b exp=%b", e, a_sel, e[0:0]);
                end
            end
            vectors++;
            if (a_en !== exp_en) begin
                miscompares++;
                $display("FAIL basic_enable_mult e=%0d got=%b exp=%b", e, a_en, exp_en);
            end
            vectors++;
            if ({a_vi, a_done, a_cmd_ready, a_busy} !== {exp_vi, exp_done, exp_ready, ~exp_ready}) begin
                miscompares++;
                $display("FAIL basic_ctrl e=%0d got(vi,done,ready,busy)=%b exp=%b", e,
                         {a_vi, a_done, a_cmd_ready, a_busy}, {exp_vi, exp_done, exp_ready, ~exp_ready});
            end
        end
    endtask

    task automatic test_count_zero();
        a_cnt = 16'd0;
        a_cmd_valid = 1'b1;
        tick();
        a_cmd_valid = 1'b0;
        vectors++;
        if ({a_lw, a_en, a_vi, a_done, a_cmd_ready} !== 7'b0000010) begin
            miscompares++;
            $display("FAIL zero_edge0 got=%b exp=%b", {a_lw, a_en, a_vi, a_done, a_cmd_ready}, 7'b0000010);
        end
        tick();
        vectors++;
        if ({a_lw, a_en, a_vi, a_done, a_cmd_ready, a_busy} !== 8'b00000010) begin
            miscompares++;
            $display("FAIL zero_edge1 got=%b exp=%b", {a_lw, a_en, a_vi, a_done, a_cmd_ready, a_busy}, 8'b00000010);
        end
    endtask

    // Two count=1 tiles with cmd_valid held; second accepted at edge 12.
    task automatic test_back_to_back();
        logic [1:0] exp_lw, exp_en;
        logic       exp_done, exp_ready, exp_vi;
        int         t;
        a_cnt = 16'd1;
        a_cmd_valid = 1'b1;
        for (int e = 0; e <= 23; e++) begin
            tick();
            t = (e < 12) ? e : e - 12;
            exp_lw    = (t == 0) ? 2'b01 : (t == 1) ? 2'b10 : 2'b00;
            exp_en    = (t >= 2 && t <= 5) ? 2'b10 : (t >= 6 && t <= 9) ? 2'b01 : 2'b00;
            exp_vi    = (t == 2);
            exp_done  = (t == 10);
            exp_ready = (t == 11);
            vectors++;
            if ({a_lw, a_en, a_vi, a_done, a_cmd_ready} !== {exp_lw, exp_en, exp_vi, exp_done, exp_ready}) begin
                miscompares++;
                $display("FAIL b2b e=%0d got(lw,en,vi,done,ready)=%b exp=%b", e,
                         {a_lw, a_en, a_vi, a_done, a_cmd_ready}, {exp_lw, exp_en, exp_vi, exp_done, exp_ready});
            end
        end
        a_cmd_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        a_cnt = 16'd2;
        a_cmd_valid = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            tick();
            a_cmd_valid = 1'b0;
        end
        vectors++;
        if (a_en !== 2'b11) begin
            miscompares++;
            $display("FAIL rstmid_pre_en got=%b exp=%b", a_en, 2'b11);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if ({a_lw, a_sel, a_en, a_vi, a_done, a_busy, a_cmd_ready} !== 9'b000000001) begin
            miscompares++;
            $display("FAIL rstmid_async got=%b exp=%b", {a_lw, a_sel, a_en, a_vi, a_done, a_busy, a_cmd_ready}, 9'b000000001);
        end
        tick();
        vectors++;
        if ({a_done, a_en, a_cmd_ready} !== 4'b0001) begin
            miscompares++;
            $display("FAIL rstmid_hold got=%b exp=%b", {a_done, a_en, a_cmd_ready}, 4'b0001);
        end
        reset = 1'b0;
        tick();
        a_cnt = 16'd1;
        a_cmd_valid = 1'b1;
        for (int e = 0; e <= 11; e++) begin
            tick();
            a_cmd_valid = 1'b0;
            if (e == 0 || e == 2 || e == 9 || e == 10 || e == 11) begin
                vectors++;
                if ({a_lw, a_en, a_done, a_cmd_ready} !==
                    ((e == 0) ? 6'b010000 : (e == 2) ? 6'b001000 : (e == 9) ? 6'b000100 :
                     (e == 10) ? 6'b000010 : 6'b000001)) begin
                    miscompares++;
                    $display("FAIL rstmid_rerun e=%0d got(lw,en,done,ready)=%b", e, {a_lw, a_en, a_done, a_cmd_ready});
                end
            end
        end
    endtask

    // N=4, L=1, count=5: eight issue slots at edges 4..11, done at edge 12.
    task automatic test_n4_l1();
        logic [3:0] exp_lw, exp_en;
        int         pulses;
        pulses = 0;
        b_cnt = 16'd5;
        b_cmd_valid = 1'b1;
        for (int e = 0; e <= 13; e++) begin
            tick();
            b_cmd_valid = 1'b0;
            if (b_vi === 1'b1) pulses++;
            case (e)
                0: exp_lw = 4'b0001;
                1: exp_lw = 4'b0010;
                2: exp_lw = 4'b0100;
                3: exp_lw = 4'b1000;
                default: exp_lw = 4'b0000;
            endcase
            case (e)
                4: exp_en = 4'b1000;
                5: exp_en = 4'b1100;
                6: exp_en = 4'b1110;
                7: exp_en = 4'b1111;
                8: exp_en = 4'b1111;
                9: exp_en = 4'b0111;
                10: exp_en = 4'b0011;
                11: exp_en = 4'b0001;
                default: exp_en = 4'b0000;
            endcase
            vectors++;
            if ({b_lw, b_en} !== {exp_lw, exp_en}) begin
                miscompares++;
                $display("FAIL n4_lw_en e=%0d got=%b exp=%b", e, {b_lw, b_en}, {exp_lw, exp_en});
            end
            if (e < 4) begin
                vectors++;
                if (b_sel !== 2'(e)) begin
                    miscompares++;
                    $display("FAIL n4_row_sel e=%0d got=%0d exp=%0d", e, b_sel, e);
                end
            end
            vectors++;
            if ({b_done, b_cmd_ready} !== {(e == 12), (e == 13)}) begin
                miscompares++;
                $display("FAIL n4_done_ready e=%0d got=%b exp=%b", e, {b_done, b_cmd_ready}, {(e == 12), (e == 13)});
            end
        end
        vectors++;
        if (pulses != 5) begin
            miscompares++;
            $display("FAIL n4_vec_issue_count got=%0d exp=5", pulses);
        end
    endtask

`ifdef SYSTOLIC_SEQ_STALL_EN
    // Stall sampled at edges 7..9, during the second issue slot.
    task automatic test_stall();
        logic [1:0] exp_en;
        a_cnt = 16'd2;
        a_cmd_valid = 1'b1;
        for (int e = 0; e <= 18; e++) begin
            tick();
            a_cmd_valid = 1'b0;
            a_stall = (e >= 6 && e <= 8);
            exp_en = (e >= 2 && e <= 5) ? 2'b10 : (e == 6) ? 2'b11 :
                     (e >= 10 && e <= 12) ? 2'b11 : (e >= 13 && e <= 16) ? 2'b01 : 2'b00;
            vectors++;
            if ({a_en, a_vi, a_done, a_cmd_ready} !== {exp_en, (e == 2 || e == 6), (e == 17), (e == 18)}) begin
                miscompares++;
                $display("FAIL stall e=%0d got(en,vi,done,ready)=%b exp=%b", e,
                         {a_en, a_vi, a_done, a_cmd_ready}, {exp_en, (e == 2 || e == 6), (e == 17), (e == 18)});
            end
        end
        a_stall = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_count_zero();
        test_back_to_back();
        tick();
        test_reset_mid();
        test_n4_l1();
`ifdef SYSTOLIC_SEQ_STALL_EN
        tick();
        test_stall();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/systolic_tile_sequencer.md
# systolic_tile_sequencer

Sequences one tile operation on the MATRIX_SIZE×MATRIX_SIZE weight-stationary systolic array: row-by-row weight load, staggered per-row multiply enables, drain, then completion. It sits between the tile command source (valid/ready) and the array's per-row `load_weight` / `enable_mult` controls, and supplies the per-vector issue strobe to the activation feeder. It runs back-to-back tiles without reset.

## Interface
- MATRIX_SIZE, 2: array dimension N (rows = columns), ≥2.
- PE_LATENCY, 4: cycles per PE hop; one issue slot lasts PE_LATENCY cycles, ≥1.
- CNT_W, 16: width of the vector-count field.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_valid  in  1  tile command present.
- cmd_ready  out  1  sequencer can accept a command (state IDLE).
- cmd_vec_count  in  CNT_W  number of activation vectors in the tile; sampled on handshake.
- stall  in  1  feeder starved; freezes sequencing (present only with SYSTOLIC_SEQ_STALL_EN).
- load_weight  out  N  one-hot row weight-load strobe.
- weight_row_sel  out  $clog2(N)  index of the row being loaded.
- enable_mult  out  N  per-row multiply enable; bit N-1 = first row enabled.
- vec_issue  out  1  one-cycle pulse: feeder presents the next activation vector.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, LOAD, COMPUTE, DRAIN, DONE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready: latch count; count≠0 → LOAD, count=0 → DONE (no load, no compute).
- LOAD: N cycles; cycle k drives load_weight=1<<k, weight_row_sel=k, k=0..N-1; then → COMPUTE.
- COMPUTE: slot counter 0..PE_LATENCY-1; at each slot start, enable_mult ← {ins, enable_mult[N-1:1]}, ins=1 while issued<count, issued increments, vec_issue=1 for that cycle. After the last 1 is inserted → DRAIN.
- DRAIN: same shifting with ins=0; the slot boundary at which the shift produces all-zero → DONE, enable_mult=0.
- DONE: done=1 for one cycle, cmd_ready=0; → IDLE.
- Issue-slot total = count+N-1; compute+drain = (count+N-1)·PE_LATENCY cycles.
- issued counter CNT_W bits, no wrap: count ≤ 2^CNT_W-1 by construction.
- cmd_valid outside IDLE is ignored, not lost (cmd_ready=0).

## Timing
- All outputs except cmd_ready and busy are registered; cmd_ready and busy decode the state register.
- Reset: state IDLE, cmd_ready=1, busy=0, load_weight=0, weight_row_sel=0, enable_mult=0, vec_issue=0, done=0, counters 0. Reset mid-tile aborts immediately with the same values; no done.
- Edge 0 = accepting edge. load_weight[k] high after edge k; first enable_mult/vec_issue after edge N; done high after edge N+(count+N-1)·PE_LATENCY; cmd_ready high the following cycle.
- count=0: done high after edge 0.
- Minimum command-to-command spacing = done cycle + 1.

## Configuration
- SYSTOLIC_SEQ_STALL_EN defined: stall port exists. stall=1 sampled in LOAD/COMPUTE/DRAIN freezes state, slot and issue counters, and the enable shift register; load_weight, enable_mult, vec_issue drive 0 during stalled cycles, then resume at the same position. Each stalled cycle delays done by one. Stall is ignored in IDLE and DONE.
- Undefined: no stall port; behaviour identical to stall tied 0.

## Structure
- Package systolic_seq_pkg: seq_state_e enum (IDLE, LOAD, COMPUTE, DRAIN, DONE), default parameter constants.
- Sub-module systolic_skew_shreg: N-bit right-shift register with shift-enable, insert bit, synchronous clear, all-zero flag; drives enable_mult.

## Test plan
- N=2, L=4, count=2 → load_weight 01 after edge 0, 10 after edge 1; enable_mult 10 after edges 2–5, 11 after edges 6–9, 01 after edges 10–13; vec_issue after edges 2 and 6; done after edge 14.
- count=0 → no load_weight or enable_mult activity; done after edge 0; cmd_ready high after edge 1.
- Back-to-back: cmd_valid held high, two tiles count=1 → second accepted the cycle after first done; no overlap of enable_mult between tiles.
- Reset asserted mid-COMPUTE → all outputs 0 immediately, cmd_ready=1, no done; next command runs from scratch.
- STALL_EN, N=2, L=4, count=2, stall high 3 cycles during slot 2 → enable_mult 0 during stall, done after edge 17.
- N=4, L=1, count=5 → eight issue slots, done after edge 12, exactly 5 vec_issue pulses.
